aap_regfile_mp: RTL and testbench

- Parametrised multi-port register file for the AAP pipeline; next generation of the 4x8 two-write/three-read file.
- Provides configurable width and depth, three combinational read ports and two synchronous write ports with defined collision priority.
- Adds a per-register pending scoreboard for decode-stage hazard detection, and a post-reset clear sequencer that zeroes the array.
- Sits between decode (reads, lock requests) and writeback (writes, unlocks).

---
 rtl/aap_regfile_pkg.sv | 20 ++
 rtl/aap_regfile_rdport.sv | 65 ++++++
 rtl/aap_regfile_mp.sv | 123 ++++++++++++
 tb/tb_aap_regfile_mp.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/aap_regfile_pkg.sv
// aap_regfile_pkg: shared types and constants for the aap_regfile_mp register file.
//   state_t        - sequencer state (CLEAR clears the array, RUN serves requests)
//   DATA_W_DEF     - default register width
//   ADDR_W_DEF     - default address width
//   depth()        - number of registers for a given address width
package aap_regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 6;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/aap_regfile_rdport.sv
// aap_regfile_rdport: one combinational read port of aap_regfile_mp.
// Optional feature macro: AAP_REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//   i_mem, i_pend          - full array contents and scoreboard bits
//   i_addr                 - read address
//   i_wr1_*, i_wr2_*       - active write ports (already gated by RUN)
//   i_lock_en, i_lock_addr - active lock request (already gated by RUN)
//   o_data, o_pend         - read data and pending bit of the addressed register
module aap_regfile_rdport
    import aap_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [depth(ADDR_W)-1:0][DATA_W-1:0] i_mem,
    input  logic [depth(ADDR_W)-1:0]             i_pend,
    input  logic [ADDR_W-1:0]                    i_addr,
    input  logic                                 i_wr1_en,
    input  logic [ADDR_W-1:0]                    i_wr1_addr,
    input  logic [DATA_W-1:0]                    i_wr1_data,
    input  logic                                 i_wr2_en,
    input  logic [ADDR_W-1:0]                    i_wr2_addr,
    input  logic [DATA_W-1:0]                    i_wr2_data,
    input  logic                                 i_lock_en,
    input  logic [ADDR_W-1:0]                    i_lock_addr,
    output logic [DATA_W-1:0]                    o_data,
    output logic                                 o_pend
);

`ifdef AAP_REGFILE_BYPASS_EN
    logic w_hit1;
    logic w_hit2;
    logic w_lock_hit;

    assign w_hit1     = i_wr1_en  && (i_wr1_addr  == i_addr);
    assign w_hit2     = i_wr2_en  && (i_wr2_addr  == i_addr);
    assign w_lock_hit = i_lock_en && (i_lock_addr == i_addr);

    // wr2 is checked last so it wins a collision, matching the array write order.
    always_comb begin
        o_data = i_mem[i_addr];
        o_pend = i_pend[i_addr];
        if (w_hit1) begin
            o_data = i_wr1_data;
            o_pend = w_lock_hit;
        end
        if (w_hit2) begin
            o_data = i_wr2_data;
            o_pend = w_lock_hit;
        end
    end
`else
    // Without forwarding the write/lock ports are not looked at.
    logic w_unused;
    assign w_unused = ^{i_wr1_en, i_wr1_addr, i_wr1_data,
                        i_wr2_en, i_wr2_addr, i_wr2_data,
                        i_lock_en, i_lock_addr};

    always_comb begin
        o_data = i_mem[i_addr];
        o_pend = i_pend[i_addr];
    end
`endif

endmodule

// File: rtl/aap_regfile_mp.sv
// aap_regfile_mp: parametrised 2-write / 3-read register file with pending scoreboard
// and a post-reset clear sequencer.
// Optional feature macro: AAP_REGFILE_BYPASS_EN (forwarding inside each read port).
// Ports:
//   clock, reset_n               - clock, synchronous active-low reset
//   busy                         - high while the array is being cleared
//   rdN_addr / rdN_data / rdN_pend (N=1..3) - combinational read ports
//   wrN_en / wrN_addr / wrN_data (N=1..2)   - synchronous write ports, wr2 wins collisions
//   lock_en / lock_addr          - mark a register pending (wins over a same-cycle write)
module aap_regfile_mp
    import aap_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              busy,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    input  logic [ADDR_W-1:0] rd3_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    output logic [DATA_W-1:0] rd3_data,
    output logic              rd1_pend,
    output logic              rd2_pend,
    output logic              rd3_pend,
    input  logic              wr1_en,
    input  logic              wr2_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [ADDR_W-1:0] wr2_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic [DATA_W-1:0] wr2_data,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr
);

    localparam int DEPTH = depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t                        r_state;
    state_t                        w_state_next;
    logic [ADDR_W-1:0]             r_clr_ptr;
    logic [DEPTH-1:0][DATA_W-1:0]  r_mem;
    logic [DEPTH-1:0]              r_pend;

    logic w_run;
    logic w_wr1;
    logic w_wr2;
    logic w_lock;

    assign w_run  = (r_state == RUN);
    assign w_wr1  = wr1_en  & w_run;
    assign w_wr2  = wr2_en  & w_run;
    assign w_lock = lock_en & w_run;
    assign busy   = ~w_run;

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= CLEAR;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR:   if (r_clr_ptr == LAST) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = CLEAR;
        endcase
    end

    // The array has no reset of its own; the clear sequencer zeroes it one entry per cycle.
    // Pending updates rely on NBA ordering: unlocks first, lock last so lock wins.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_clr_ptr <= '0;
            r_pend    <= '0;
        end else if (!w_run) begin
            r_mem[r_clr_ptr] <= '0;
            r_clr_ptr        <= r_clr_ptr + 1'b1;
        end else begin
            if (w_wr1) begin
                r_mem[wr1_addr]  <= wr1_data;
                r_pend[wr1_addr] <= 1'b0;
            end
            if (w_wr2) begin
                r_mem[wr2_addr]  <= wr2_data;
                r_pend[wr2_addr] <= 1'b0;
            end
            if (w_lock) r_pend[lock_addr] <= 1'b1;
        end
    end

    logic [2:0][ADDR_W-1:0] w_rd_addr;
    logic [2:0][DATA_W-1:0] w_rd_data;
    logic [2:0]             w_rd_pend;

    assign w_rd_addr = {rd3_addr, rd2_addr, rd1_addr};
    assign {rd3_data, rd2_data, rd1_data} = w_rd_data;
    assign {rd3_pend, rd2_pend, rd1_pend} = w_rd_pend;

    for (genvar g = 0; g < 3; g++) begin : g_rd
        aap_regfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rdport (
            .i_mem       (r_mem),
            .i_pend      (r_pend),
            .i_addr      (w_rd_addr[g]),
            .i_wr1_en    (w_wr1),
            .i_wr1_addr  (wr1_addr),
            .i_wr1_data  (wr1_data),
            .i_wr2_en    (w_wr2),
            .i_wr2_addr  (wr2_addr),
            .i_wr2_data  (wr2_data),
            .i_lock_en   (w_lock),
            .i_lock_addr (lock_addr),
            .o_data      (w_rd_data[g]),
            .o_pend      (w_rd_pend[g])
        );
    end

endmodule

// File: tb/tb_aap_regfile_mp.sv
// tb_aap_regfile_mp: directed self-checking bench for aap_regfile_mp (default 16x64).
module tb_aap_regfile_mp;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        busy;
    logic [5:0]  rd1_addr, rd2_addr, rd3_addr;
    logic [15:0] rd1_data, rd2_data, rd3_data;
    logic        rd1_pend, rd2_pend, rd3_pend;
    logic        wr1_en, wr2_en;
    logic [5:0]  wr1_addr, wr2_addr;
    logic [15:0] wr1_data, wr2_data;
    logic        lock_en;
    logic [5:0]  lock_addr;

    int errors = 0;
    int checks = 0;
    int cnt;

    always #5 clock = ~clock;

    aap_regfile_mp dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .busy      (busy),
        .rd1_addr  (rd1_addr),
        .rd2_addr  (rd2_addr),
        .rd3_addr  (rd3_addr),
        .rd1_data  (rd1_data),
        .rd2_data  (rd2_data),
        .rd3_data  (rd3_data),
        .rd1_pend  (rd1_pend),
        .rd2_pend  (rd2_pend),
        .rd3_pend  (rd3_pend),
        .wr1_en    (wr1_en),
        .wr2_en    (wr2_en),
        .wr1_addr  (wr1_addr),
        .wr2_addr  (wr2_addr),
        .wr1_data  (wr1_data),
        .wr2_data  (wr2_data),
        .lock_en   (lock_en),
        .lock_addr (lock_addr)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr1_en = 0; wr2_en = 0; lock_en = 0;
    endtask

    initial begin
        reset_n = 0;
        rd1_addr = 0; rd2_addr = 0; rd3_addr = 0;
        wr1_addr = 0; wr2_addr = 0; wr1_data = 0; wr2_data = 0; lock_addr = 0;
        idle();

        // 1. reset and clear sequencing
        tick(); tick();
        chk("busy_in_reset", busy, 1);
        reset_n = 1;
        cnt = 0;
        while (busy && cnt < 200) begin tick(); cnt++; end
        chk("clear_cycles", cnt, 64);
        rd1_addr = 0; rd2_addr = 31; rd3_addr = 63;
        #1;
        chk("clr_rd1", rd1_data, 0);
        chk("clr_rd2", rd2_data, 0);
        chk("clr_rd3", rd3_data, 0);
        chk("clr_pend", {rd1_pend, rd2_pend, rd3_pend}, 0);

        // 2./6. write addr 5, same-cycle read depends on forwarding
        wr1_en = 1; wr1_addr = 5; wr1_data = 16'h1234; rd1_addr = 5;
        #1;
`ifdef AAP_REGFILE_BYPASS_EN
        chk("rdw_same_cycle", rd1_data, 16'h1234);
`else
        chk("rdw_same_cycle", rd1_data, 16'h0000);
`endif
        tick(); idle();
        #1;
        chk("wr1_addr5", rd1_data, 16'h1234);
        wr2_en = 1; wr2_addr = 63; wr2_data = 16'hFFFF;
        tick(); idle();
        rd3_addr = 63;
        #1;
        chk("wr2_addr63", rd3_data, 16'hFFFF);

        // 3. collision, wr2 wins
        wr1_en = 1; wr1_addr = 7; wr1_data = 16'hAAAA;
        wr2_en = 1; wr2_addr = 7; wr2_data = 16'h5555;
        tick(); idle();
        rd2_addr = 7;
        #1;
        chk("collision_data", rd2_data, 16'h5555);
        chk("collision_pend", rd2_pend, 0);

        // 4. scoreboard
        lock_en = 1; lock_addr = 9;
        tick(); idle();
        rd2_addr = 9;
        #1;
        chk("lock_pend", rd2_pend, 1);
        lock_en = 1; lock_addr = 9;
        tick(); idle();
        #1;
        chk("relock_pend", rd2_pend, 1);
        wr2_en = 1; wr2_addr = 9; wr2_data = 16'h0909;
        tick(); idle();
        #1;
        chk("unlock_pend", rd2_pend, 0);
        chk("unlock_data", rd2_data, 16'h0909);
        wr1_en = 1; wr1_addr = 9; wr1_data = 16'h4242; lock_en = 1; lock_addr = 9;
        tick(); idle();
        #1;
        chk("lockwins_pend", rd2_pend, 1);
        chk("lockwins_data", rd2_data, 16'h4242);

        // 6. forwarding with wr2 priority, addr 12
        wr1_en = 1; wr1_addr = 12; wr1_data = 16'hBEEF;
        wr2_en = 1; wr2_addr = 12; wr2_data = 16'hCAFE;
        rd1_addr = 12;
        #1;
`ifdef AAP_REGFILE_BYPASS_EN
        chk("byp_prio", rd1_data, 16'hCAFE);
`else
        chk("byp_prio", rd1_data, 16'h0000);
`endif
        chk("byp_pend", rd1_pend, 0);
        tick(); idle();
        #1;
        chk("byp_after", rd1_data, 16'hCAFE);

        // 5. reset mid-RUN with an in-flight write to addr 3
        wr1_en = 1; wr1_addr = 3; wr1_data = 16'h3333;
        reset_n = 0;
        tick();
        chk("busy_after_rst", busy, 1);
        reset_n = 1;
        // requests during CLEAR must be ignored
        wr1_en = 1; wr1_addr = 0; wr1_data = 16'hDEAD;
        lock_en = 1; lock_addr = 20;
        cnt = 0;
        while (busy && cnt < 200) begin tick(); cnt++; end
        idle();
        chk("clear_cycles2", cnt, 64);
        rd1_addr = 3; rd2_addr = 9; rd3_addr = 0;
        #1;
        chk("rst_wr_discard", rd1_data, 0);
        chk("rst_pend9", rd2_pend, 0);
        chk("rst_addr9", rd2_data, 0);
        chk("clr_ignores_wr", rd3_data, 0);
        rd1_addr = 20;
        #1;
        chk("clr_ignores_lock", rd1_pend, 0);
        rd1_addr = 5;
        #1;
        chk("rst_addr5", rd1_data, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
